// File: rtl/cp0_intr_ctrl_if.sv
// -----------------------------------------------------------------------------
// cp0_intr_ctrl_if
// Purpose : bundles the pipeline/peripheral side of the CP0 interrupt
//           controller: mfc0/mtc0 access, UART event inputs, and the
//           interrupt request/acknowledge pair.
// Signals :
//   cp0_sel[4:0]    register number for mfc0/mtc0
//   cp0_we          mtc0 write strobe
//   cp0_wdata[31:0] mtc0 write data
//   cp0_rdata[31:0] mfc0 read data (combinational from cp0_sel)
//   uart_rx_valid   one-cycle pulse per received UART byte
//   uart_tx_ready   level, UART transmitter idle
//   int_ack         one-cycle pulse when the pipeline takes the interrupt
//   epc_in[31:0]    PC of the first unretired instruction, valid with int_ack
//   irq_req         registered interrupt request to the pipeline
//
// Handshake semantics: there is no backpressure anywhere on this interface.
// uart_rx_valid, cp0_we and int_ack are single-cycle qualifiers sampled on
// every rising clk edge they are high; each high cycle is one event.
// uart_tx_ready is a level whose 0->1 transition is the event. irq_req is a
// level held while an enabled cause is pending; int_ack is the pipeline's
// acceptance and carries epc_in in the same cycle.
// -----------------------------------------------------------------------------
interface cp0_intr_ctrl_if;
  logic [4:0]  cp0_sel;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        uart_rx_valid;
  logic        uart_tx_ready;
  logic        int_ack;
  logic [31:0] epc_in;
  logic        irq_req;

  modport master (
    output cp0_sel, cp0_we, cp0_wdata, uart_rx_valid, uart_tx_ready,
           int_ack, epc_in,
    input  cp0_rdata, irq_req
  );

  modport slave (
    input  cp0_sel, cp0_we, cp0_wdata, uart_rx_valid, uart_tx_ready,
           int_ack, epc_in,
    output cp0_rdata, irq_req
  );
endinterface

// File: rtl/cp0_intr_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_intr_ctrl
// Purpose : minimal MIPS-style CP0 interrupt block. Implements Count (9),
//           Compare (11), Status (12), Cause (13) and EPC (14), a prescaled
//           timer, UART RX/TX interrupt sources and a registered irq_req.
// Parameters:
//   TICK_DIV  core clock cycles per Count increment (1..65535)
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous, active-high reset
//   bus   cp0_intr_ctrl_if.slave (see interface file for signal list)
// -----------------------------------------------------------------------------
module cp0_intr_ctrl #(
  parameter int TICK_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  cp0_intr_ctrl_if.slave  bus
);

  localparam logic [4:0]  SEL_COUNT   = 5'd9;
  localparam logic [4:0]  SEL_COMPARE = 5'd11;
  localparam logic [4:0]  SEL_STATUS  = 5'd12;
  localparam logic [4:0]  SEL_CAUSE   = 5'd13;
  localparam logic [4:0]  SEL_EPC     = 5'd14;
  localparam logic [15:0] PRESC_LAST  = 16'(TICK_DIV - 1);

  logic [15:0] presc_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] epc_q;
  logic        ie_q;
  logic [7:0]  im_q;
  logic        ip7_q, ip6_q, ip3_q, ip2_q;
  logic        tx_ready_q;
  logic        irq_q;

  logic        tick;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        timer_match;
  logic        tx_rise;
  logic        ip7_d, ip6_d, ip3_d, ip2_d;
  logic        irq_d;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  // With TICK_DIV=1 PRESC_LAST is 0, so presc_q stays 0 and every cycle ticks.
  assign tick       = (presc_q == PRESC_LAST);

  assign wr_count   = bus.cp0_we && (bus.cp0_sel == SEL_COUNT);
  assign wr_compare = bus.cp0_we && (bus.cp0_sel == SEL_COMPARE);
  assign wr_status  = bus.cp0_we && (bus.cp0_sel == SEL_STATUS);
  assign wr_cause   = bus.cp0_we && (bus.cp0_sel == SEL_CAUSE);
  assign wr_epc     = bus.cp0_we && (bus.cp0_sel == SEL_EPC);

  // A software Count write suppresses both the increment and the match check.
  assign timer_match = tick && !wr_count && (count_q == compare_q);
  assign tx_rise     = bus.uart_tx_ready && !tx_ready_q;

  assign status_rd = {16'b0, im_q, 7'b0, ie_q};
  assign cause_rd  = {16'b0, ip7_q, ip6_q, 2'b0, ip3_q, ip2_q, 10'b0};

  // Pending-bit next state: software load first, hardware set last so a
  // same-cycle hardware event always survives a software clear.
  always_comb begin
    ip7_d = ip7_q;
    if (wr_compare) ip7_d = 1'b0;
    if (wr_cause)   ip7_d = bus.cp0_wdata[15];
    if (timer_match) ip7_d = 1'b1;

    ip6_d = wr_cause ? bus.cp0_wdata[14] : ip6_q;
    ip3_d = (wr_cause ? bus.cp0_wdata[11] : ip3_q) | tx_rise;
    ip2_d = (wr_cause ? bus.cp0_wdata[10] : ip2_q) | bus.uart_rx_valid;
  end

  // irq_req is computed from the pre-edge register values, giving one cycle
  // of latency from the enabling condition; int_ack drops it immediately.
  assign irq_d = ie_q && (|(im_q & cause_rd[15:8])) && !bus.int_ack;

  always_comb begin
    bus.cp0_rdata = 32'b0;
    case (bus.cp0_sel)
      SEL_COUNT:   bus.cp0_rdata = count_q;
      SEL_COMPARE: bus.cp0_rdata = compare_q;
      SEL_STATUS:  bus.cp0_rdata = status_rd;
      SEL_CAUSE:   bus.cp0_rdata = cause_rd;
      SEL_EPC:     bus.cp0_rdata = epc_q;
      default:     bus.cp0_rdata = 32'b0;
    endcase
  end

  assign bus.irq_req = irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= 16'b0;
      count_q    <= 32'b0;
      compare_q  <= 32'hFFFF_FFFF;
      epc_q      <= 32'b0;
      ie_q       <= 1'b0;
      im_q       <= 8'b0;
      ip7_q      <= 1'b0;
      ip6_q      <= 1'b0;
      ip3_q      <= 1'b0;
      ip2_q      <= 1'b0;
      tx_ready_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      presc_q    <= tick ? 16'b0 : presc_q + 16'd1;
      tx_ready_q <= bus.uart_tx_ready;
      irq_q      <= irq_d;

      if (wr_count)  count_q <= bus.cp0_wdata;
      else if (tick) count_q <= count_q + 32'd1;

      if (wr_compare) compare_q <= bus.cp0_wdata;

      // IM always follows a Status write; int_ack overrides IE.
      if (wr_status) begin
        im_q <= bus.cp0_wdata[15:8];
        ie_q <= bus.cp0_wdata[0];
      end
      if (bus.int_ack) ie_q <= 1'b0;

      if (bus.int_ack)   epc_q <= bus.epc_in;
      else if (wr_epc)   epc_q <= bus.cp0_wdata;

      ip7_q <= ip7_d;
      ip6_q <= ip6_d;
      ip3_q <= ip3_d;
      ip2_q <= ip2_d;
    end
  end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
module tb_cp0_intr_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rst4;

  always #5 clk = ~clk;

  cp0_intr_ctrl_if if1 ();
  cp0_intr_ctrl_if if4 ();

  cp0_intr_ctrl #(.TICK_DIV(1)) dut1 (.clk(clk), .rst(rst),  .bus(if1.slave));
  cp0_intr_ctrl #(.TICK_DIV(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));

  localparam logic [4:0] R_COUNT = 5'd9;
  localparam logic [4:0] R_CMP   = 5'd11;
  localparam logic [4:0] R_STAT  = 5'd12;
  localparam logic [4:0] R_CAUSE = 5'd13;
  localparam logic [4:0] R_EPC   = 5'd14;

  // scoreboard
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          tests_run = 0;
  int          fail_cnt  = 0;

  task automatic sb_push(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    tests_run++;
    if (exp_q.size() == 0) begin
      fail_cnt++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fail_cnt++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // driver tasks: inputs change only on the falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit d4, input logic [4:0] sel, input logic [31:0] data);
    @(negedge clk);
    if (d4) begin
      if4.cp0_we = 1'b1; if4.cp0_sel = sel; if4.cp0_wdata = data;
    end else begin
      if1.cp0_we = 1'b1; if1.cp0_sel = sel; if1.cp0_wdata = data;
    end
    @(negedge clk);
    if4.cp0_we = 1'b0;
    if1.cp0_we = 1'b0;
  endtask

  task automatic chk_reg(input bit d4, input logic [4:0] sel, input logic [31:0] e,
                         input string tag);
    if (d4) if4.cp0_sel = sel;
    else    if1.cp0_sel = sel;
    #1;
    sb_push(tag, e);
    sb_check(d4 ? if4.cp0_rdata : if1.cp0_rdata);
  endtask

  task automatic chk_irq(input logic e, input string tag);
    sb_push(tag, {31'b0, e});
    sb_check({31'b0, if1.irq_req});
  endtask

  initial begin
    rst  = 1'b1;
    rst4 = 1'b1;
    if1.cp0_sel = '0; if1.cp0_we = 1'b0; if1.cp0_wdata = '0;
    if1.uart_rx_valid = 1'b0; if1.uart_tx_ready = 1'b0;
    if1.int_ack = 1'b0; if1.epc_in = '0;
    if4.cp0_sel = '0; if4.cp0_we = 1'b0; if4.cp0_wdata = '0;
    if4.uart_rx_valid = 1'b0; if4.uart_tx_ready = 1'b0;
    if4.int_ack = 1'b0; if4.epc_in = '0;

    // reset values
    idle(2);
    chk_reg(0, R_COUNT, 32'h0,         "rst_count");
    chk_reg(0, R_CMP,   32'hFFFF_FFFF, "rst_compare");
    chk_reg(0, R_STAT,  32'h0,         "rst_status");
    chk_reg(0, R_CAUSE, 32'h0,         "rst_cause");
    chk_reg(0, R_EPC,   32'h0,         "rst_epc");
    chk_irq(1'b0, "rst_irq");
    @(negedge clk);
    rst = 1'b0;

    // timer match, irq latency, int_ack
    wr(0, R_COUNT, 32'h1000);
    wr(0, R_CMP,   32'd5);
    wr(0, R_STAT,  32'h8001);
    wr(0, R_COUNT, 32'd0);
    idle(5);
    chk_reg(0, R_COUNT, 32'd5,   "timer_count5");
    chk_reg(0, R_CAUSE, 32'h0,   "timer_pre_match");
    idle(1);
    chk_reg(0, R_CAUSE, 32'h8000, "timer_ip7_set");
    chk_irq(1'b0, "timer_irq_latency");
    idle(1);
    chk_irq(1'b1, "timer_irq");
    if1.int_ack = 1'b1; if1.epc_in = 32'h0040_0020;
    @(negedge clk);
    if1.int_ack = 1'b0;
    chk_reg(0, R_EPC,  32'h0040_0020, "ack_epc");
    chk_reg(0, R_STAT, 32'h8000,      "ack_status");
    chk_irq(1'b0, "ack_irq_drop");
    idle(1);
    chk_irq(1'b0, "ack_irq_stays_low");
    chk_reg(0, R_CAUSE, 32'h8000, "ack_cause_kept");
    wr(0, R_CMP, 32'h8000_0000);
    chk_reg(0, R_CAUSE, 32'h0, "compare_wr_clears_ip7");

    // Count write beats a matching tick
    wr(0, R_CMP, 32'h50);
    @(negedge clk);
    if1.cp0_we = 1'b1; if1.cp0_sel = R_COUNT; if1.cp0_wdata = 32'h50;
    @(negedge clk);
    if1.cp0_wdata = 32'h100;
    @(negedge clk);
    if1.cp0_we = 1'b0;
    chk_reg(0, R_COUNT, 32'h100, "count_wr_wins");
    chk_reg(0, R_CAUSE, 32'h0,   "count_wr_no_match");
    wr(0, R_CMP, 32'h8000_0000);

    // wrap
    wr(0, R_COUNT, 32'hFFFF_FFFF);
    chk_reg(0, R_COUNT, 32'hFFFF_FFFF, "wrap_pre");
    idle(1);
    chk_reg(0, R_COUNT, 32'h0, "wrap_zero");

    // write masks and unmapped selects
    wr(0, R_STAT, 32'hFFFF_FFFF);
    chk_reg(0, R_STAT, 32'h0000_FF01, "status_mask");
    wr(0, R_CAUSE, 32'hFFFF_FFFF);
    chk_reg(0, R_CAUSE, 32'h0000_CC00, "cause_mask");
    wr(0, R_CAUSE, 32'h0);
    wr(0, 5'd5, 32'h1234);
    chk_reg(0, 5'd5, 32'h0, "unmapped_5");
    chk_reg(0, 5'd0, 32'h0, "unmapped_0");

    // UART RX
    wr(0, R_STAT, 32'h0401);
    @(negedge clk);
    if1.uart_rx_valid = 1'b1;
    @(negedge clk);
    if1.uart_rx_valid = 1'b0;
    chk_reg(0, R_CAUSE, 32'h0400, "rx_ip2");
    chk_irq(1'b0, "rx_irq_latency");
    idle(1);
    chk_irq(1'b1, "rx_irq");
    wr(0, R_CAUSE, 32'h0);
    chk_reg(0, R_CAUSE, 32'h0, "rx_cleared");
    idle(1);
    chk_irq(1'b0, "rx_irq_cleared");

    // hardware set vs software clear in one cycle
    @(negedge clk);
    if1.uart_rx_valid = 1'b1;
    if1.cp0_we = 1'b1; if1.cp0_sel = R_CAUSE; if1.cp0_wdata = 32'h0;
    @(negedge clk);
    if1.uart_rx_valid = 1'b0; if1.cp0_we = 1'b0;
    chk_reg(0, R_CAUSE, 32'h0400, "collision_set_wins");
    wr(0, R_CAUSE, 32'h0);

    // int_ack with Status and EPC writes
    @(negedge clk);
    if1.cp0_we = 1'b1; if1.cp0_sel = R_STAT; if1.cp0_wdata = 32'h0A01;
    if1.int_ack = 1'b1; if1.epc_in = 32'h2222_0000;
    @(negedge clk);
    if1.cp0_we = 1'b0; if1.int_ack = 1'b0;
    chk_reg(0, R_STAT, 32'h0A00, "ack_vs_status");
    @(negedge clk);
    if1.cp0_we = 1'b1; if1.cp0_sel = R_EPC; if1.cp0_wdata = 32'h1111;
    if1.int_ack = 1'b1; if1.epc_in = 32'h2222;
    @(negedge clk);
    if1.cp0_we = 1'b0; if1.int_ack = 1'b0;
    chk_reg(0, R_EPC, 32'h2222, "ack_vs_epc");
    wr(0, R_EPC, 32'h3333);
    chk_reg(0, R_EPC, 32'h3333, "epc_write");
    @(negedge clk);
    if1.cp0_we = 1'b1; if1.cp0_sel = R_EPC; if1.cp0_wdata = 32'h4444;
    chk_reg(0, R_EPC, 32'h3333, "no_forwarding");
    @(negedge clk);
    if1.cp0_we = 1'b0;
    chk_reg(0, R_EPC, 32'h4444, "epc_after_edge");

    // UART TX rising edge
    wr(0, R_STAT, 32'h0);
    @(negedge clk);
    if1.uart_tx_ready = 1'b1;
    idle(10);
    chk_reg(0, R_CAUSE, 32'h0800, "tx_ip3_once");
    wr(0, R_CAUSE, 32'h0);
    idle(3);
    chk_reg(0, R_CAUSE, 32'h0, "tx_level_no_reset");
    @(negedge clk);
    if1.uart_tx_ready = 1'b0;
    idle(2);
    @(negedge clk);
    if1.uart_tx_ready = 1'b1;
    idle(2);
    chk_reg(0, R_CAUSE, 32'h0800, "tx_second_edge");
    wr(0, R_CAUSE, 32'h0);

    // reset mid-interrupt, overriding same-cycle write/ack/rx
    wr(0, R_STAT, 32'h8001);
    wr(0, R_CAUSE, 32'h8000);
    idle(1);
    chk_irq(1'b1, "pre_reset_irq");
    @(negedge clk);
    rst = 1'b1;
    if1.cp0_we = 1'b1; if1.cp0_sel = R_STAT; if1.cp0_wdata = 32'h0000_FF01;
    if1.int_ack = 1'b1; if1.epc_in = 32'h5555; if1.uart_rx_valid = 1'b1;
    @(negedge clk);
    if1.cp0_we = 1'b0; if1.int_ack = 1'b0; if1.uart_rx_valid = 1'b0;
    chk_reg(0, R_COUNT, 32'h0,         "mid_rst_count");
    chk_reg(0, R_CMP,   32'hFFFF_FFFF, "mid_rst_compare");
    chk_reg(0, R_STAT,  32'h0,         "mid_rst_status");
    chk_reg(0, R_CAUSE, 32'h0,         "mid_rst_cause");
    chk_reg(0, R_EPC,   32'h0,         "mid_rst_epc");
    chk_irq(1'b0, "mid_rst_irq");
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk_irq(1'b0, "post_rst_irq");
    chk_reg(0, R_COUNT, 32'd3, "post_rst_count");

    // prescaler, TICK_DIV=4
    @(negedge clk);
    rst4 = 1'b0;
    idle(11);
    chk_reg(1, R_COUNT, 32'd2, "presc_11");
    idle(1);
    chk_reg(1, R_COUNT, 32'd3, "presc_12");
    wr(1, R_COUNT, 32'hFFFF_FFFF);
    chk_reg(1, R_COUNT, 32'hFFFF_FFFF, "presc_wr");
    idle(4);
    chk_reg(1, R_COUNT, 32'h0, "presc_wrap");

    if (exp_q.size() != 0) begin
      tests_run++;
      fail_cnt++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
